// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage data-memory access unit sitting directly in front of the
//   MEM/WB pipeline register. It turns the load/store controls of the
//   instruction in MEM into one req/ack transaction on the data-memory bus
//   and holds the pipeline in stall until that transaction has completed
//   or timed out. Little-endian byte lanes, 32-bit word datapath.
//
//   Ports
//     clk, rst        clock (rising edge) / synchronous active-high reset
//     memRdM, memWrM  load / store in MEM (store wins if both are set)
//     memSizeM        00 byte, 01 half, 10 word, 11 reserved
//     memUnsignedM    1 = zero-extend load data, 0 = sign-extend
//     aluOutM         effective byte address
//     writeDataM      right-aligned store data
//     readDataM       extended load data for MEM/WB (registered)
//     stallM          freeze upstream stages, bubble into MEM/WB
//     misalignM       misaligned or reserved-size access (combinational)
//     busErrM         one-cycle pulse when a transaction times out
//     dmem_*          data-memory bus: req/we/addr/be/wdata out,
//                     ack/rdata in (rdata valid with the ack pulse)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRdM,
    input  logic        memWrM,
    input  logic [1:0]  memSizeM,
    input  logic        memUnsignedM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        busErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    // Request attributes captured at issue; used to extract load data when
    // the ack arrives, since the MEM inputs are not trusted after IDLE.
    logic [1:0]       size_p1;
    logic [1:0]       off_p1;
    logic             uns_p1;

    logic             rd_or_wr;
    logic             access;

    // Pick the addressed lane(s) from a bus word and extend to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] rdata,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? $signed({24'd0, b}) : $signed({{24{b[7]}}, b});
            2'b01:   r = uns ? $signed({16'd0, h}) : $signed({{16{h[15]}}, h});
            2'b10:   r = $signed(rdata);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_enables(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so the slave can simply
    // apply the byte enables.
    function automatic logic [31:0] lane_wdata(
        input logic [1:0]  size,
        input logic [31:0] wd
    );
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    assign rd_or_wr  = memRdM | memWrM;
    assign misalignM = rd_or_wr & ((memSizeM == 2'b11) |
                                   ((memSizeM == 2'b01) & aluOutM[0]) |
                                   ((memSizeM == 2'b10) & (aluOutM[1:0] != 2'b00)));
    assign access    = rd_or_wr & ~misalignM;

    // DONE never stalls: the pipeline advances on the edge that leaves DONE,
    // which is when MEM/WB captures readDataM.
    always_comb begin
        stallM = 1'b0;
        case (state)
            IDLE:    stallM = access;
            BUSY:    stallM = 1'b1;
            default: stallM = 1'b0;
        endcase
    end

    // ---- issue (IDLE) / bus wait (BUSY) / hand-off (DONE) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            readDataM  <= '0;
            busErrM    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            size_p1    <= '0;
            off_p1     <= '0;
            uns_p1     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busErrM   <= 1'b0;
                    readDataM <= '0;
                    if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrM;
                        dmem_addr  <= {aluOutM[31:2], 2'b00};
                        dmem_be    <= lane_enables(memSizeM, aluOutM[1:0]);
                        dmem_wdata <= memWrM ? lane_wdata(memSizeM, writeDataM) : 32'd0;
                        size_p1    <= memSizeM;
                        off_p1     <= aluOutM[1:0];
                        uns_p1     <= memUnsignedM;
                        count      <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        readDataM <= dmem_we ? 32'd0
                                             : load_extend(dmem_rdata, size_p1, off_p1, uns_p1);
                        state     <= DONE;
                    end else if (count == CNT_LAST) begin
                        dmem_req  <= 1'b0;
                        readDataM <= '0;
                        busErrM   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result has been taken by MEM/WB on this edge.
                    busErrM   <= 1'b0;
                    readDataM <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
